lockstep_result_checker: RTL and testbench

//  Synthesizable N-lane lockstep checker for pipelined ALU variants with differing latencies.
//  All lanes receive the same op stream; per-lane delay lines and FIFOs realign results to issue order.

---
 rtl/lockstep_if.sv | 35 +++
 rtl/lockstep_result_checker.sv | 164 ++++++++++++++++
 tb/tb_lockstep_result_checker.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lockstep_if.sv
// Lockstep checker bus: op stream and lane results in,
// aligned comparison results and statistics out.
interface lockstep_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 3,
  parameter int CNT_W = 16
);
  logic                   issue;
  logic [LANES*WIDTH-1:0] lane_result;
  logic                   cmp_hold;
  logic                   cmp_valid;
  logic [CNT_W-1:0]       cmp_idx;
  logic [LANES-1:0]       cmp_mask;
  logic [CNT_W-1:0]       chk_count;
  logic [CNT_W-1:0]       err_count;
  logic                   first_err_vld;
  logic [CNT_W-1:0]       first_err_idx;
  logic                   overflow;

  modport master (
    output issue, lane_result, cmp_hold,
    input  cmp_valid, cmp_idx, cmp_mask,
    input  chk_count, err_count,
    input  first_err_vld, first_err_idx,
    input  overflow
  );

  modport slave (
    input  issue, lane_result, cmp_hold,
    output cmp_valid, cmp_idx, cmp_mask,
    output chk_count, err_count,
    output first_err_vld, first_err_idx,
    output overflow
  );
endinterface

// File: rtl/lockstep_result_checker.sv
// N-lane lockstep checker: realigns per-lane results to
// issue order and compares every lane against lane 0.
module lockstep_result_checker #(
  parameter int WIDTH   = 32,
  parameter int LANES   = 3,
  parameter int MAX_LAT = 8,
  parameter logic [8*LANES-1:0] LAT_VEC =
    {8'd3, 8'd3, 8'd1},
  parameter int AW      = 3,
  parameter int CNT_W   = 16
) (
  input logic      clk,
  input logic      reset,
  lockstep_if.slave bus
);
  function automatic int lat_of(int i);
    return int'(LAT_VEC[8*i+:8]);
  endfunction

  function automatic int lat_max();
    int m = 0;
    for (int i = 0; i < LANES; i++)
      if (lat_of(i) > m) m = lat_of(i);
    return m;
  endfunction

  function automatic int lat_min();
    int m = 255;
    for (int i = 0; i < LANES; i++)
      if (lat_of(i) < m) m = lat_of(i);
    return m;
  endfunction

  function automatic bit lat_ok();
    bit ok = 1'b1;
    for (int i = 0; i < LANES; i++)
      if (lat_of(i) < 1 || lat_of(i) > MAX_LAT)
        ok = 1'b0;
    return ok;
  endfunction

  localparam int LMAX  = lat_max();
  localparam int LMIN  = lat_min();
  localparam int DEPTH = 2 ** AW;

  if (LANES < 2 || !lat_ok()) begin : g_bad_lat
    $error("lane latency out of range");
  end
  if (LMAX - LMIN + 2 > DEPTH) begin : g_bad_depth
    $error("FIFO too shallow for latency skew");
  end

  typedef enum logic [1:0] {
    EMPTY, PARTIAL, FULL
  } fifo_st_t;

  // One shared valid chain: every lane sees the same op stream.
  logic [LMAX-1:0]  vld;
  logic [LANES-1:0] nonempty;
  logic [LANES-1:0] drop;
  logic [LANES-1:0] mask_c;
  logic [WIDTH-1:0] head [LANES];
  logic             pop;

  always_ff @(posedge clk) begin
    if (reset) vld <= '0;
    else       vld <= (vld << 1) | LMAX'(bus.issue);
  end

  assign pop = (&nonempty) && !bus.cmp_hold;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int L = lat_of(g);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    fifo_st_t         st;
    logic             push;
    logic             wr;

    assign push = vld[L-1];
    assign wr   = push && (st != FULL || pop);
    assign drop[g]     = push && st == FULL && !pop;
    assign nonempty[g] = st != EMPTY;
    assign head[g]     = mem[rp];

    always_ff @(posedge clk) begin
      if (wr) mem[wp] <= bus.lane_result[WIDTH*g+:WIDTH];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wp <= '0;
        rp <= '0;
        st <= EMPTY;
      end else begin
        if (wr)  wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        unique case (1'b1)
          wr && !pop:
            st <= (wp + 1'b1 == rp) ? FULL : PARTIAL;
          pop && !wr:
            st <= (rp + 1'b1 == wp) ? EMPTY : PARTIAL;
          default: st <= st;
        endcase
      end
    end
  end

  always_comb begin
    mask_c = '0;
    for (int i = 1; i < LANES; i++)
      mask_c[i] = head[i] != head[0];
  end

  logic             valid_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] cidx_q;
  logic [LANES-1:0] mask_q;
  logic [CNT_W-1:0] chk_q;
  logic [CNT_W-1:0] err_q;
  logic             fe_vld_q;
  logic [CNT_W-1:0] fe_idx_q;
  logic             ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      cidx_q   <= '0;
      mask_q   <= '0;
      chk_q    <= '0;
      err_q    <= '0;
      fe_vld_q <= 1'b0;
      fe_idx_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= pop;
      if (pop) begin
        mask_q <= mask_c;
        cidx_q <= idx_q;
        idx_q  <= idx_q + 1'b1;
        if (chk_q != '1) chk_q <= chk_q + 1'b1;
        if (|mask_c) begin
          if (err_q != '1) err_q <= err_q + 1'b1;
          if (!fe_vld_q) begin
            fe_vld_q <= 1'b1;
            fe_idx_q <= idx_q;
          end
        end
      end
      if (|drop) ovf_q <= 1'b1;
    end
  end

  assign bus.cmp_valid     = valid_q;
  assign bus.cmp_idx       = cidx_q;
  assign bus.cmp_mask      = mask_q;
  assign bus.chk_count     = chk_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_vld = fe_vld_q;
  assign bus.first_err_idx = fe_idx_q;
  assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_lockstep_result_checker.sv
// Directed bench: lanes model one ALU with per-lane latency,
// optional corruption of one lane's results.
module tb_lockstep_result_checker;
  localparam int W = 32;
  localparam int N = 3;

  int lat [N] = '{1, 3, 3};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lockstep_if #(.WIDTH(W), .LANES(N), .CNT_W(16)) b ();
  lockstep_if #(.WIDTH(W), .LANES(N), .CNT_W(4))  b4 ();

  assign b4.issue       = b.issue;
  assign b4.lane_result = b.lane_result;
  assign b4.cmp_hold    = b.cmp_hold;

  lockstep_result_checker #(.CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  lockstep_result_checker #(.CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4)
  );

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int next_op = 0;
  int iss_op [0:4095];
  int op_cyc [0:1023];
  logic [W-1:0] val [0:1023];
  int bad_lane = -1;
  int bad_op = -1;
  bit bad_all = 1'b0;

  int p_cyc [$];
  int p_idx [$];
  logic [N-1:0] p_mask [$];
  int p4_idx [$];

  task automatic tick(input bit iss, input bit hold,
                      input bit rst);
    int c;
    logic [W-1:0] v;
    reset = rst;
    b.issue = iss;
    b.cmp_hold = hold;
    iss_op[cyc] = iss ? next_op : -1;
    if (iss) begin
      op_cyc[next_op] = cyc;
      next_op++;
    end
    for (int i = 0; i < N; i++) begin
      c = cyc - lat[i];
      v = '0;
      if (c >= 0 && iss_op[c] >= 0) begin
        v = val[iss_op[c]];
        if (i == bad_lane &&
            (bad_all || iss_op[c] == bad_op))
          v = v ^ 32'd1;
      end
      b.lane_result[W*i+:W] = v;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (b.cmp_valid) begin
      p_cyc.push_back(cyc);
      p_idx.push_back(int'(b.cmp_idx));
      p_mask.push_back(b.cmp_mask);
    end
    if (b4.cmp_valid) p4_idx.push_back(int'(b4.cmp_idx));
  endtask

  task automatic clear_log();
    p_cyc.delete();
    p_idx.delete();
    p_mask.delete();
    p4_idx.delete();
  endtask

  task automatic do_reset();
    bad_lane = -1;
    bad_op = -1;
    bad_all = 1'b0;
    tick(1'b0, 1'b0, 1'b1);
    clear_log();
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if (b.cmp_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_valid got %b want 0", b.cmp_valid);
    end
    vecs++;
    if (b.cmp_idx !== 16'd0 || b.cmp_mask !== 3'd0) begin
      errs++;
      $display("FAIL reset_idx_mask got %0d/%b want 0/000",
               b.cmp_idx, b.cmp_mask);
    end
    vecs++;
    if (b.chk_count !== 16'd0 || b.err_count !== 16'd0) begin
      errs++;
      $display("FAIL reset_counts got %0d/%0d want 0/0",
               b.chk_count, b.err_count);
    end
    vecs++;
    if (b.first_err_vld !== 1'b0 || b.first_err_idx !== 16'd0
        || b.overflow !== 1'b0) begin
      errs++;
      $display("FAIL reset_sticky got %b/%0d/%b want 0/0/0",
               b.first_err_vld, b.first_err_idx, b.overflow);
    end
  endtask

  task automatic run_burst(input int n, output int first);
    first = next_op;
    for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int first;
    int bad;
    do_reset();
    run_burst(10, first);
    vecs++;
    if (p_idx.size() != 10) begin
      errs++;
      $display("FAIL b2b_pulses got %0d want 10", p_idx.size());
    end
    bad = 0;
    for (int k = 0; k < p_idx.size() && k < 10; k++)
      if (p_idx[k] != k || p_mask[k] !== 3'b000) bad++;
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL b2b_idx_mask got %0d bad want 0", bad);
    end
    vecs++;
    if (p_cyc.size() == 0 || p_cyc[0] - op_cyc[first] != 5) begin
      errs++;
      $display("FAIL b2b_latency got %0d want 5",
               p_cyc.size() ? p_cyc[0] - op_cyc[first] : -1);
    end
    vecs++;
    if (b.chk_count !== 16'd10 || b.err_count !== 16'd0) begin
      errs++;
      $display("FAIL b2b_counts got %0d/%0d want 10/0",
               b.chk_count, b.err_count);
    end
  endtask

  task automatic test_single_error();
    int first;
    int bad;
    do_reset();
    bad_lane = 2;
    bad_op = next_op + 4;
    run_burst(10, first);
    bad = 0;
    for (int k = 0; k < p_idx.size(); k++)
      if (p_mask[k] !== ((k == 4) ? 3'b100 : 3'b000)) bad++;
    vecs++;
    if (p_idx.size() != 10 || bad != 0) begin
      errs++;
      $display("FAIL err_mask got %0d pulses %0d bad want 10/0",
               p_idx.size(), bad);
    end
    vecs++;
    if (b.err_count !== 16'd1) begin
      errs++;
      $display("FAIL err_count got %0d want 1", b.err_count);
    end
    vecs++;
    if (b.first_err_vld !== 1'b1 || b.first_err_idx !== 16'd4) begin
      errs++;
      $display("FAIL first_err got %b/%0d want 1/4",
               b.first_err_vld, b.first_err_idx);
    end
  endtask

  task automatic test_sparse();
    int first;
    int bad;
    do_reset();
    first = next_op;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int k = 0; k < p_idx.size() && k < 6; k++)
      if (p_idx[k] != k || p_mask[k] !== 3'b000 ||
          p_cyc[k] - op_cyc[first+k] != 5) bad++;
    vecs++;
    if (p_idx.size() != 6 || bad != 0) begin
      errs++;
      $display("FAIL sparse got %0d pulses %0d bad want 6/0",
               p_idx.size(), bad);
    end
  endtask

  task automatic test_hold_overflow();
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (n == 9) begin
        vecs++;
        if (b.overflow !== 1'b0) begin
          errs++;
          $display("FAIL ovf_early got %b want 0", b.overflow);
        end
      end
      if (n == 10) begin
        vecs++;
        if (b.overflow !== 1'b1) begin
          errs++;
          $display("FAIL ovf_9th_push got %b want 1", b.overflow);
        end
      end
    end
    vecs++;
    if (p_idx.size() != 0) begin
      errs++;
      $display("FAIL hold_no_cmp got %0d pulses want 0",
               p_idx.size());
    end
    for (int k = 0; k < 20; k++) tick(1'b0, 1'b0, 1'b0);
    vecs++;
    if (b.overflow !== 1'b1) begin
      errs++;
      $display("FAIL ovf_sticky got %b want 1", b.overflow);
    end
    do_reset();
    vecs++;
    if (b.overflow !== 1'b0) begin
      errs++;
      $display("FAIL ovf_clear got %b want 0", b.overflow);
    end
  endtask

  task automatic test_mid_reset();
    int first;
    do_reset();
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    clear_log();
    vecs++;
    if (b.chk_count !== 16'd0 || b.cmp_idx !== 16'd0) begin
      errs++;
      $display("FAIL mid_rst_counts got %0d/%0d want 0/0",
               b.chk_count, b.cmp_idx);
    end
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b0);
    vecs++;
    if (p_idx.size() != 0) begin
      errs++;
      $display("FAIL mid_rst_stale got %0d pulses want 0",
               p_idx.size());
    end
    run_burst(1, first);
    vecs++;
    if (p_idx.size() != 1 || p_idx[0] != 0 ||
        p_cyc[0] - op_cyc[first] != 5) begin
      errs++;
      $display("FAIL mid_rst_next got %0d pulses idx %0d want 1/0",
               p_idx.size(), p_idx.size() ? p_idx[0] : -1);
    end
  endtask

  task automatic test_saturate();
    int first;
    do_reset();
    bad_lane = 1;
    bad_all = 1'b1;
    run_burst(20, first);
    vecs++;
    if (p4_idx.size() != 20 || p4_idx[19] != 3) begin
      errs++;
      $display("FAIL sat_wrap got %0d pulses last %0d want 20/3",
               p4_idx.size(), p4_idx.size() ? p4_idx[$] : -1);
    end
    vecs++;
    if (b4.chk_count !== 4'd15 || b4.err_count !== 4'd15) begin
      errs++;
      $display("FAIL sat_counts got %0d/%0d want 15/15",
               b4.chk_count, b4.err_count);
    end
    vecs++;
    if (b.chk_count !== 16'd20 || b.err_count !== 16'd20) begin
      errs++;
      $display("FAIL wide_counts got %0d/%0d want 20/20",
               b.chk_count, b.err_count);
    end
    vecs++;
    if (b.first_err_idx !== 16'd0 || p_mask.size() == 0 ||
        p_mask[0] !== 3'b010) begin
      errs++;
      $display("FAIL sat_first got %0d want 0",
               b.first_err_idx);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      val[i] = (i % 2 == 1) ? 32'((i + 3) * (i + 7))
                            : 32'(i + 100 + 2 * i);
    for (int i = 0; i < 4096; i++) iss_op[i] = -1;
    reset = 1'b1;
    b.issue = 1'b0;
    b.cmp_hold = 1'b0;
    b.lane_result = '0;
    test_reset();
    test_back_to_back();
    test_single_error();
    test_sparse();
    test_hold_overflow();
    test_mid_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
